// File: rtl/uart_mmio_bridge_pkg.sv
// Shared constants and types for the UART MMIO bridge: register offsets,
// STATUS bit positions and the TX drain FSM state type.
package uart_mmio_bridge_pkg;

    // Register offsets, taken from addr[4:3]
    localparam logic [1:0] OffTx   = 2'd0;
    localparam logic [1:0] OffRx   = 2'd1;
    localparam logic [1:0] OffStat = 2'd2;
    localparam logic [1:0] OffRsvd = 2'd3;

    // STATUS bit positions
    localparam int unsigned StatReadyBit   = 0;
    localparam int unsigned StatTxFullBit  = 1;
    localparam int unsigned StatTxEmptyBit = 2;
    localparam int unsigned StatRxNoneBit  = 3;
    localparam int unsigned StatTxOvfBit   = 4;

    // Host reply meaning "no character available"
    localparam logic [7:0] RxNoChar = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } tx_state_e;

    // Assemble the STATUS word; bit 0 always reads as 1 (device ready)
    function automatic logic [63:0] status_word(input logic tx_ovf, input logic rx_none,
                                                input logic tx_empty, input logic tx_full);
        logic [63:0] s;
        s = '0;
        s[StatReadyBit]   = 1'b1;
        s[StatTxFullBit]  = tx_full;
        s[StatTxEmptyBit] = tx_empty;
        s[StatRxNoneBit]  = rx_none;
        s[StatTxOvfBit]   = tx_ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_mmio_bridge_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers. A push while full is accepted
// only when a pop happens in the same cycle (the pop frees the slot first).
module uart_mmio_bridge_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Occupancy never exceeds DEPTH, so its MSB alone flags full
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count == '0);
    assign full_o  = count[AW];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers, flushed by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART responder: TXDATA stores are queued and paced out on
// io_uart_out_*, RXDATA loads poll the host through io_uart_in_*.
module uart_mmio_bridge
    import uart_mmio_bridge_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h1000_0000,
    parameter int unsigned TX_DEPTH  = 8,
    parameter int unsigned TX_GAP    = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        io_uart_out_valid,
    output logic [7:0]  io_uart_out_ch,
    output logic        io_uart_in_valid,
    input  logic [7:0]  io_uart_in_ch
);

    localparam int unsigned GapW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

    logic        hit, is_wr, rd_hit, tx_push, stat_wr, rx_poll, pop;
    logic [1:0]  off;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_head;
    logic        unused_bits;

    tx_state_e   state_q, state_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_ch_q, out_ch_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_none_q, rx_none_d;
    logic [63:0] rdata_q, rdata_d;

    // Address decode; only 8-byte-aligned byte 0 carries data
    assign hit     = en & (addr[63:5] == BASE_ADDR[63:5]);
    assign off     = addr[4:3];
    assign is_wr   = |we;
    assign rd_hit  = hit & ~is_wr;
    assign tx_push = hit & is_wr & we[0] & (off == OffTx);
    assign stat_wr = hit & is_wr & (off == OffStat);
    assign rx_poll = rd_hit & (off == OffRx) & ~reset;

    assign unused_bits = ^{addr[2:0], wdata[63:8], wdata[4]};

    uart_mmio_bridge_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (tx_push),
        .wdata_i (wdata[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // TX drain FSM: pop on leaving IDLE so the byte is on the pins during SEND
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        pop         = 1'b0;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_ch_d    = fifo_head;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (TX_GAP > 0) begin
                    state_d = StGap;
                    gap_d   = GapW'(TX_GAP - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_q == '0) state_d = StIdle;
                else             gap_d   = gap_q - GapW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky overflow, RX no-char flag and read-data mux
    always_comb begin
        tx_ovf_d  = tx_ovf_q;
        rx_none_d = rx_none_q;
        rdata_d   = rdata_q;
        if (stat_wr && wdata[StatTxOvfBit]) tx_ovf_d = 1'b0;
        // A push into a full FIFO survives only when the drain pops that cycle
        if (tx_push && fifo_full && !pop) tx_ovf_d = 1'b1;
        if (rx_poll) rx_none_d = (io_uart_in_ch == RxNoChar);
        if (en && !hit) begin
            rdata_d = '0;
        end else if (rd_hit) begin
            unique case (off)
                OffRx:   rdata_d = {56'b0, io_uart_in_ch};
                OffStat: rdata_d = status_word(tx_ovf_q, rx_none_q, fifo_empty, fifo_full);
                default: rdata_d = '0;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            tx_ovf_q    <= 1'b0;
            rx_none_q   <= 1'b1;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_none_q   <= rx_none_d;
            rdata_q     <= rdata_d;
        end
    end

    // Strobes are masked while reset is asserted so no stale byte escapes
    assign io_uart_out_valid = out_valid_q & ~reset;
    assign io_uart_out_ch    = out_ch_q;
    assign io_uart_in_valid  = rx_poll;
    assign rdata             = rdata_q;

endmodule
